// File: rtl/ysyx_22050854_fetch_pkg.sv
// rtl/ysyx_22050854_fetch_pkg.sv - shared types and constants for the instruction fetch unit
package ysyx_22050854_fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_DROP
`ifdef FETCH_MISALIGN_CHECK_EN
        , ST_HALT
`endif
    } fetch_state_t;

    typedef struct packed {
        logic        fault;
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam fetch_entry_t EMPTY_ENTRY = '{fault: 1'b0, pc: 64'h0, instr: NOP_INSTR};

endpackage

// File: rtl/ysyx_22050854_fetch_queue.sv
// rtl/ysyx_22050854_fetch_queue.sv - synchronous instruction FIFO with flush and occupancy count
module ysyx_22050854_fetch_queue
    import ysyx_22050854_fetch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(QDEPTH):0] count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   mem [QDEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;

    // A flush may coincide with a push: the pushed entry becomes the sole occupant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? PW'(1) : '0;
            count  <= push ? CW'(1) : '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[flush ? '0 : wr_ptr] <= push_data;
    end

    assign head = (count == '0) ? EMPTY_ENTRY : mem[rd_ptr];

endmodule

// File: rtl/ysyx_22050854_fetch_unit.sv
// rtl/ysyx_22050854_fetch_unit.sv - PC owner and imem fetcher feeding decode; optional FETCH_MISALIGN_CHECK_EN
module ysyx_22050854_fetch_unit
    import ysyx_22050854_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        out_fault
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

    fetch_state_t  state;
    logic [63:0]   pc;
    logic          started;
    logic          outstanding;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          push;
    logic          handshake;
    logic          busy_on_redirect;
    logic          misaligned;
    logic [63:0]   redirect_target;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned      = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign redirect_target = redirect_pc;
`else
    logic unused_lsbs;
    assign unused_lsbs     = ^redirect_pc[1:0];
    assign misaligned      = 1'b0;
    assign redirect_target = {redirect_pc[63:2], 2'b00};
`endif

    // started keeps the request low for the whole reset-release cycle
    assign imem_req_valid   = started & (state == ST_REQ) & (count < QDEPTH_C);
    assign imem_req_addr    = pc;
    assign handshake        = imem_req_valid & imem_req_ready;
    assign busy_on_redirect = handshake | (outstanding & ~imem_rsp_valid);

    always_comb begin
        push      = ~redirect_valid & (state == ST_WAIT) & imem_rsp_valid;
        push_data = '{fault: 1'b0, pc: pc - 64'd4, instr: imem_rsp_data};
        if (misaligned) begin
            push      = 1'b1;
            push_data = '{fault: 1'b1, pc: redirect_pc, instr: NOP_INSTR};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_REQ;
            pc          <= RESET_PC;
            started     <= 1'b0;
            outstanding <= 1'b0;
        end else begin
            started <= 1'b1;
            if (redirect_valid) begin
                pc          <= redirect_target;
                outstanding <= busy_on_redirect;
                state       <= busy_on_redirect ? ST_DROP : ST_REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
                if (misaligned) state <= ST_HALT;
`endif
            end else begin
                if (handshake)           outstanding <= 1'b1;
                else if (imem_rsp_valid) outstanding <= 1'b0;
                case (state)
                    ST_REQ: if (handshake) begin
                        state <= ST_WAIT;
                        pc    <= pc + 64'd4;
                    end
                    ST_WAIT, ST_DROP: if (imem_rsp_valid) state <= ST_REQ;
                    default: ;
                endcase
            end
        end
    end

    ysyx_22050854_fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (out_valid & out_ready),
        .head      (head),
        .count     (count)
    );

    assign out_valid = (count != '0) & ~redirect_valid;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign out_fault = head.fault;

endmodule

// File: tb/tb_ysyx_22050854_fetch_unit.sv
// tb/tb_ysyx_22050854_fetch_unit.sv - directed self-checking bench for the fetch unit
module tb_ysyx_22050854_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_fault;

    int          passed = 0;
    int          total = 0;
    logic        mem_auto = 1'b1;
    logic        hs;
    logic [63:0] hs_addr;

    always #5 clk = ~clk;

    ysyx_22050854_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_fault      (out_fault)
    );

    // One clock; memory answers an accepted request in the following cycle with {addr[23:0], 8'h93}.
    task automatic step;
        #1;
        hs      = imem_req_valid & imem_req_ready;
        hs_addr = imem_req_addr;
        @(posedge clk);
        #1;
        imem_rsp_valid = mem_auto & hs;
        imem_rsp_data  = {hs_addr[23:0], 8'h93};
    endtask

    // Leaves the bench in cycle 1: first request to the reset PC is being presented.
    task automatic do_reset;
        rst = 1'b1; redirect_valid = 1'b0; imem_req_ready = 1'b1;
        out_ready = 1'b1; mem_auto = 1'b1;
        step; step;
        rst = 1'b0;
        step;
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_auto = 1'b1;
        step; step;
        #1;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid got %0b want 0", imem_req_valid); else passed++;
        total++; if (imem_req_addr !== 64'h8000_0000) $display("FAIL reset_req_addr got %h want 8000_0000", imem_req_addr); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passed++;
        total++; if (out_instr !== 32'h0000_0013) $display("FAIL reset_out_instr got %h want 00000013", out_instr); else passed++;
        total++; if (out_pc !== 64'h0) $display("FAIL reset_out_pc got %h want 0", out_pc); else passed++;
        total++; if (out_fault !== 1'b0) $display("FAIL reset_out_fault got %0b want 0", out_fault); else passed++;
    endtask

    task automatic test_first_fetch;
        rst = 1'b0;
        step; #1;
        total++; if (imem_req_valid !== 1'b1) $display("FAIL first_req_valid got %0b want 1", imem_req_valid); else passed++;
        total++; if (imem_req_addr !== 64'h8000_0000) $display("FAIL first_req_addr got %h want 8000_0000", imem_req_addr); else passed++;
        step; #1;
        total++; if (out_valid !== 1'b0) $display("FAIL first_early_out_valid got %0b want 0", out_valid); else passed++;
        step; #1;
        total++; if (out_valid !== 1'b1) $display("FAIL first_out_valid got %0b want 1", out_valid); else passed++;
        total++; if (out_instr !== 32'h0000_0093) $display("FAIL first_out_instr got %h want 00000093", out_instr); else passed++;
        total++; if (out_pc !== 64'h8000_0000) $display("FAIL first_out_pc got %h want 8000_0000", out_pc); else passed++;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004) $display("FAIL first_next_req got v=%0b a=%h want v=1 a=8000_0004", imem_req_valid, imem_req_addr); else passed++;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        repeat (10) step;
        #1;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL bp_req_valid got %0b want 0", imem_req_valid); else passed++;
        total++; if (imem_req_addr !== 64'h8000_0008) $display("FAIL bp_req_addr got %h want 8000_0008", imem_req_addr); else passed++;
        total++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0000) $display("FAIL bp_head got v=%0b pc=%h want v=1 pc=8000_0000", out_valid, out_pc); else passed++;
        out_ready = 1'b1;
        step; #1;
        total++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0004) $display("FAIL bp_second got v=%0b pc=%h want v=1 pc=8000_0004", out_valid, out_pc); else passed++;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0008) $display("FAIL bp_resume got v=%0b a=%h want v=1 a=8000_0008", imem_req_valid, imem_req_addr); else passed++;
        step; #1;
        total++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %0b want 0", out_valid); else passed++;
        step; #1;
        total++; if (out_pc !== 64'h8000_0008 || out_instr !== 32'h0000_0893) $display("FAIL bp_third got pc=%h i=%h want pc=8000_0008 i=00000893", out_pc, out_instr); else passed++;
    endtask

    task automatic test_redirect_outstanding;
        do_reset;
        mem_auto = 1'b0;
        step;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
        #1;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL rdo_wait_req got %0b want 0", imem_req_valid); else passed++;
        step;
        redirect_valid = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL rdo_drop_req got %0b want 0", imem_req_valid); else passed++;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0001;
        step;
        mem_auto = 1'b1;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100) $display("FAIL rdo_new_req got v=%0b a=%h want v=1 a=8000_0100", imem_req_valid, imem_req_addr); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL rdo_stale_dropped got %0b want 0", out_valid); else passed++;
        step; step; #1;
        total++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0100) $display("FAIL rdo_out got v=%0b pc=%h want v=1 pc=8000_0100", out_valid, out_pc); else passed++;
        total++; if (out_instr !== 32'h0001_0093) $display("FAIL rdo_instr got %h want 00010093", out_instr); else passed++;
    endtask

    task automatic test_redirect_with_rsp;
        do_reset;
        step;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
        #1;
        total++; if (imem_rsp_valid !== 1'b1 || out_valid !== 1'b0) $display("FAIL rdr_same_cycle got rsp=%0b ov=%0b want rsp=1 ov=0", imem_rsp_valid, out_valid); else passed++;
        step;
        redirect_valid = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100) $display("FAIL rdr_next_req got v=%0b a=%h want v=1 a=8000_0100", imem_req_valid, imem_req_addr); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL rdr_dropped got %0b want 0", out_valid); else passed++;
        step; step; #1;
        total++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0100) $display("FAIL rdr_out got v=%0b pc=%h want v=1 pc=8000_0100", out_valid, out_pc); else passed++;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL rdr_mask_head got %0b want 0", out_valid); else passed++;
        step;
        redirect_valid = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) $display("FAIL rdr_drop got rv=%0b ov=%0b want 0 0", imem_req_valid, out_valid); else passed++;
        step; #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0200) $display("FAIL rdr_after_drop got v=%0b a=%h want v=1 a=8000_0200", imem_req_valid, imem_req_addr); else passed++;
    endtask

    task automatic test_req_stall;
        do_reset;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) $display("FAIL stall_hold[%0d] got v=%0b a=%h want v=1 a=8000_0000", i, imem_req_valid, imem_req_addr); else passed++;
            step;
        end
        imem_req_ready = 1'b1;
        step; step; #1;
        total++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0000) $display("FAIL stall_out got v=%0b pc=%h want v=1 pc=8000_0000", out_valid, out_pc); else passed++;
    endtask

    task automatic test_misalign;
        do_reset;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
        step;
        redirect_valid = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        total++; if (out_valid !== 1'b1 || out_fault !== 1'b1) $display("FAIL mis_fault got v=%0b f=%0b want 1 1", out_valid, out_fault); else passed++;
        total++; if (out_pc !== 64'h8000_0102 || out_instr !== 32'h0000_0013) $display("FAIL mis_entry got pc=%h i=%h want 8000_0102 00000013", out_pc, out_instr); else passed++;
        repeat (3) step;
        #1;
        total++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) $display("FAIL mis_halt got rv=%0b ov=%0b want 0 0", imem_req_valid, out_valid); else passed++;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
        step;
        redirect_valid = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0300) $display("FAIL mis_resume got v=%0b a=%h want v=1 a=8000_0300", imem_req_valid, imem_req_addr); else passed++;
`else
        total++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) $display("FAIL mis_drop got rv=%0b ov=%0b want 0 0", imem_req_valid, out_valid); else passed++;
        step; #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100) $display("FAIL mis_aligned_req got v=%0b a=%h want v=1 a=8000_0100", imem_req_valid, imem_req_addr); else passed++;
        step; step; #1;
        total++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0100 || out_fault !== 1'b0) $display("FAIL mis_out got v=%0b pc=%h f=%0b want 1 8000_0100 0", out_valid, out_pc, out_fault); else passed++;
`endif
    endtask

    initial begin
        test_reset;
        test_first_fetch;
        test_backpressure;
        test_redirect_outstanding;
        test_redirect_with_rsp;
        test_req_stall;
        test_misalign;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ysyx_22050854_fetch_unit.md
# ysyx_22050854_fetch_unit

Instruction fetch unit for the RV64 core: owns the PC, fetches 32-bit instruction words from instruction memory over a valid/ready request/response interface, and delivers them to the decode stage through a small instruction queue. Branch, jump and trap redirects flush the queue and discard in-flight fetches. It is the producer side of the decoder's `instr` input.

## Interface
- `RESET_PC`, default 64'h8000_0000: PC fetched first after reset.
- `QDEPTH`, default 2: instruction-queue entries, power of two, ≥2.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `redirect_valid` in 1: flush and restart fetch at `redirect_pc` (jal/jalr/taken branch/ecall/mret).
- `redirect_pc` in 64: new fetch target.
- `imem_req_valid` out 1: fetch request.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out 64: fetch address (word aligned).
- `imem_rsp_valid` in 1: response data valid; always accepted, no ready.
- `imem_rsp_data` in 32: instruction word.
- `out_valid` out 1: queue head valid to decoder.
- `out_ready` in 1: decoder consumes head.
- `out_instr` out 32: instruction word.
- `out_pc` out 64: PC of `out_instr`.
- `out_fault` out 1: misaligned-target fault marker (0 when feature compiled out).

## Operation
- State machine: REQ (drive request), WAIT (one accepted request outstanding), DROP (outstanding response to discard), HALT (fault entry queued, no fetch).
- At most one outstanding request. REQ asserts `imem_req_valid` only when `count + 0 < QDEPTH` (one free slot reserved for the outstanding response); otherwise REQ holds with valid low.
- REQ: on `imem_req_valid & imem_req_ready` → WAIT, `pc <= pc + 4` (64-bit wrap-around, no check).
- WAIT: on `imem_rsp_valid` enqueue {data, fetch pc} → REQ.
- Redirect (highest priority, any state): queue flushed (count 0), `pc <= redirect_pc`. If a request is outstanding, or the request handshake completes in the redirect cycle → DROP; else → REQ. A response arriving in the redirect cycle is discarded and clears the outstanding flag.
- DROP: on `imem_rsp_valid` discard data → REQ. A further redirect in DROP only updates `pc`.
- `out_valid = (count != 0) & ~redirect_valid`; pop on `out_valid & out_ready`. Simultaneous push and pop when full is legal; count unchanged.
- `imem_req_valid` must stay asserted with stable address until accepted, unless a redirect occurs.

## Timing
- Reset values: `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`, `out_valid`=0, `out_instr`=32'h0000_0013, `out_pc`=0, `out_fault`=0, state REQ, count 0.
- First cycle after `rst` deasserts: `imem_req_valid`=1, addr `RESET_PC`.
- Response in cycle t → `out_valid` in t+1 (registered queue). Next request asserted in t+1.
- Redirect in cycle t → `out_valid`=0 in t; request to `redirect_pc` in t+1 if nothing outstanding, else one cycle after the stale response.
- Reset mid-operation discards everything; a stale response arriving after reset is ignored (outstanding flag cleared).

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: redirect with `redirect_pc[1:0] != 0` issues no request; pushes one entry {instr 32'h0000_0013, pc=redirect_pc, fault=1} and enters HALT until the next redirect.
- Undefined: `redirect_pc[1:0]` ignored (forced to 0); `out_fault` tied 0; HALT state absent.

## Structure
- Shared package: fetch-state enum, `NOP_INSTR` (32'h0000_0013), `RESET_PC` default.
- One sub-module: `ysyx_22050854_fetch_queue` (synchronous FIFO of {fault, pc, instr}, flush input, count output).

## Test plan
- Reset release, memory ready with 1-cycle response 32'h0000_0093 → request addr 0x8000_0000 in cycle 1, `out_instr`=0x93, `out_pc`=0x8000_0000 in cycle 3.
- `out_ready`=0 for 10 cycles → exactly QDEPTH entries queued, `imem_req_valid` low, no lost or duplicated PC.
- Redirect to 0x8000_0100 while request outstanding → stale response discarded, next request addr 0x8000_0100, first `out_pc`=0x8000_0100.
- Redirect in same cycle as `imem_rsp_valid` → response dropped, `out_valid` 0 that cycle, next fetch 0x8000_0100.
- `imem_req_ready` held low 5 cycles → `imem_req_valid` and addr stable throughout.
- With `FETCH_MISALIGN_CHECK_EN`, redirect to 0x8000_0102 → one entry with `out_fault`=1, `out_pc`=0x8000_0102, no memory request until next redirect.
